// File: rtl/p_decoder_seq.sv
// Sequenced 2-to-4 decoder: each accepted code drives its one-hot line for
// HOLD_CYCLES cycles, then GAP_CYCLES all-zero cycles, with a sticky overrun flag.
module p_decoder_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic y1,
    input  logic y0,
    input  logic e_in,
    input  logic clr,
    output logic d3,
    output logic d2,
    output logic d1,
    output logic d0,
    output logic v_out,
    output logic ready,
    output logic ovf
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_cnt;
    logic [3:0] w_nextCnt;
    logic [1:0] r_code;
    logic [1:0] w_nextCode;
    logic [3:0] r_d;
    logic [3:0] w_nextD;
    logic       r_vOut;
    logic       r_ovf;
    logic       w_overrun;

    function automatic logic [3:0] oneHot(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    // The d lines are computed for the next cycle so they assert on the accepting edge itself.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextCode  = r_code;
        w_nextD     = 4'b0000;
        w_overrun   = e_in && (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (e_in) begin
                    w_nextCode  = {y1, y0};
                    w_nextCnt   = HOLD_LOAD;
                    w_nextState = HOLD;
                    w_nextD     = oneHot({y1, y0});
                end
            end
            HOLD: begin
                if (r_cnt == 4'd0) begin
                    if (GAP_CYCLES > 0) begin
                        w_nextState = GAP;
                        w_nextCnt   = GAP_LOAD;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                    w_nextD   = oneHot(r_code);
                end
            end
            GAP: begin
                if (r_cnt == 4'd0) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_code  <= 2'b00;
            r_d     <= 4'b0000;
            r_vOut  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_code  <= w_nextCode;
            r_d     <= w_nextD;
            r_vOut  <= |w_nextD;
        end
    end

    // Overrun set takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_overrun) begin
            r_ovf <= 1'b1;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign d3    = r_d[3];
    assign d2    = r_d[2];
    assign d1    = r_d[1];
    assign d0    = r_d[0];
    assign v_out = r_vOut;
    assign ready = (r_state == IDLE);
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_p_decoder_seq.sv
// Directed bench for p_decoder_seq: a default instance plus a HOLD=1/GAP=0 corner instance.
module tb_p_decoder_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic y1 = 1'b0, y0 = 1'b0, eIn = 1'b0;
    logic d3, d2, d1, d0, vOut, ready, ovf;
    logic fy1 = 1'b0, fy0 = 1'b0, fEIn = 1'b0;
    logic fd3, fd2, fd1, fd0, fVOut, fReady, fOvf;

    int vecCount = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    p_decoder_seq dut (
        .clk(clk), .rst_n(rst_n), .y1(y1), .y0(y0), .e_in(eIn), .clr(clr),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0), .v_out(vOut), .ready(ready), .ovf(ovf)
    );

    p_decoder_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dutFast (
        .clk(clk), .rst_n(rst_n), .y1(fy1), .y0(fy0), .e_in(fEIn), .clr(clr),
        .d3(fd3), .d2(fd2), .d1(fd1), .d0(fd0), .v_out(fVOut), .ready(fReady), .ovf(fOvf)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        eIn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecCount++;
        if ({d3, d2, d1, d0, vOut, ready, ovf} !== 7'b0000010) begin
            missCount++;
            $display("[TB] FAIL reset_state: got d=%b v=%b rdy=%b ovf=%b, want d=0000 v=0 rdy=1 ovf=0",
                     {d3, d2, d1, d0}, vOut, ready, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        @(negedge clk);
        {y1, y0} = 2'b10;
        eIn = 1'b1;
        @(posedge clk);
        #1 eIn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecCount++;
            if ({d3, d2, d1, d0, vOut, ready} !== 6'b010010) begin
                missCount++;
                $display("[TB] FAIL single_hold[%0d]: got d=%b v=%b rdy=%b, want d=0100 v=1 rdy=0",
                         i, {d3, d2, d1, d0}, vOut, ready);
            end
        end
        @(negedge clk);
        vecCount++;
        if ({d3, d2, d1, d0, vOut, ready} !== 6'b000000) begin
            missCount++;
            $display("[TB] FAIL single_gap: got d=%b v=%b rdy=%b, want d=0000 v=0 rdy=0",
                     {d3, d2, d1, d0}, vOut, ready);
        end
        @(negedge clk);
        vecCount++;
        if ({d3, d2, d1, d0, ready} !== 5'b00001) begin
            missCount++;
            $display("[TB] FAIL single_idle: got d=%b rdy=%b, want d=0000 rdy=1", {d3, d2, d1, d0}, ready);
        end
    endtask

    task automatic test_all_codes();
        logic [3:0] expD;
        for (int c = 0; c < 4; c++) begin
            int waited = 0;
            @(negedge clk);
            while (ready !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (ready !== 1'b1) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL codes_ready_timeout: got rdy=%b, want rdy=1", ready);
            end
            {y1, y0} = 2'(c);
            eIn = 1'b1;
            expD = 4'b0001 << c;
            @(posedge clk);
            #1 eIn = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                vecCount++;
                if ({d3, d2, d1, d0} !== expD || vOut !== 1'b1) begin
                    missCount++;
                    $display("[TB] FAIL code%0d_hold[%0d]: got d=%b v=%b, want d=%b v=1",
                             c, i, {d3, d2, d1, d0}, vOut, expD);
                end
            end
            @(negedge clk);
            vecCount++;
            if ({d3, d2, d1, d0, vOut} !== 5'b00000) begin
                missCount++;
                $display("[TB] FAIL code%0d_release: got d=%b v=%b, want d=0000 v=0", c, {d3, d2, d1, d0}, vOut);
            end
        end
        vecCount++;
        if (ovf !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL codes_ovf: got ovf=%b, want 0", ovf);
        end
    endtask

    task automatic test_overrun();
        @(negedge clk);
        {y1, y0} = 2'b01;
        eIn = 1'b1;
        @(posedge clk);
        #1 eIn = 1'b0;
        @(negedge clk);
        {y1, y0} = 2'b11;
        eIn = 1'b1;
        @(posedge clk);
        #1 eIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecCount++;
            if ({d3, d2, d1, d0} !== 4'b0010 || ovf !== 1'b1) begin
                missCount++;
                $display("[TB] FAIL overrun_hold[%0d]: got d=%b ovf=%b, want d=0010 ovf=1", i, {d3, d2, d1, d0}, ovf);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecCount++;
            if (d3 !== 1'b0 || ovf !== 1'b1) begin
                missCount++;
                $display("[TB] FAIL overrun_after[%0d]: got d3=%b ovf=%b, want d3=0 ovf=1", i, d3, ovf);
            end
        end
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        vecCount++;
        if (ovf !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL overrun_clr: got ovf=%b, want 0", ovf);
        end
        // Overrun and clear on the same edge must leave the flag set.
        {y1, y0} = 2'b00;
        eIn = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1 begin
            clr = 1'b0;
            eIn = 1'b0;
        end
        @(negedge clk);
        vecCount++;
        if (ovf !== 1'b1 || {d3, d2, d1, d0} !== 4'b0001) begin
            missCount++;
            $display("[TB] FAIL set_wins: got ovf=%b d=%b, want ovf=1 d=0001", ovf, {d3, d2, d1, d0});
        end
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        {y1, y0} = 2'b11;
        eIn = 1'b1;
        @(posedge clk);
        #1 eIn = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vecCount++;
        if ({d3, d2, d1, d0, vOut, ready, ovf} !== 7'b0000010) begin
            missCount++;
            $display("[TB] FAIL async_reset: got d=%b v=%b rdy=%b ovf=%b, want d=0000 v=0 rdy=1 ovf=0",
                     {d3, d2, d1, d0}, vOut, ready, ovf);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        {y1, y0} = 2'b01;
        eIn = 1'b1;
        @(posedge clk);
        #1 eIn = 1'b0;
        @(negedge clk);
        vecCount++;
        if ({d3, d2, d1, d0} !== 4'b0010) begin
            missCount++;
            $display("[TB] FAIL first_after_reset: got d=%b, want d=0010", {d3, d2, d1, d0});
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic expD3;
        @(negedge clk);
        {fy1, fy0} = 2'b11;
        fEIn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            expD3 = (i % 2 == 0);
            vecCount++;
            if ({fd3, fd2, fd1, fd0} !== {expD3, 3'b000} || fVOut !== expD3 || fReady !== !expD3) begin
                missCount++;
                $display("[TB] FAIL back_to_back[%0d]: got d=%b v=%b rdy=%b, want d=%b v=%b rdy=%b",
                         i, {fd3, fd2, fd1, fd0}, fVOut, fReady, {expD3, 3'b000}, expD3, !expD3);
            end
        end
        fEIn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_all_codes();
        test_overrun();
        test_reset_mid_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
